// File: rtl/data_memory_unit.sv
// Byte-addressable data memory for the load/store stage: lane-masked stores, extended loads,
// fixed-latency pipelined responses and a post-reset clear sequence that zeroes every word.
module data_memory_unit #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic              ReqWrite,
  input  logic [ADDR_W-1:0] ReqAddr,
  input  logic [1:0]        ReqSize,
  input  logic              ReqUnsigned,
  input  logic [DATA_W-1:0] ReqWData,
  output logic              RspValid,
  output logic [DATA_W-1:0] RspData,
  output logic              RspErr,
  output logic              Busy
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(BYTES);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  typedef enum logic {S_CLEAR, S_READY} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  clr_idx_q, clr_idx_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              accept;
  logic [OFF_W-1:0]  off;
  logic [IDX_W-1:0]  idx;
  int unsigned       nbytes;
  int unsigned       nbits;
  logic              out_of_range;
  logic              bad_size;
  logic              misaligned;
  logic              req_err;

  logic              mem_we;
  logic [IDX_W-1:0]  mem_idx;
  logic [BYTES-1:0]  mem_be;
  logic [DATA_W-1:0] mem_wdata;

  logic [DATA_W-1:0] rd_shift;
  logic [DATA_W-1:0] ext_mask;
  logic              sign_bit;
  logic [DATA_W-1:0] load_val;
  logic [DATA_W-1:0] rsp_data_in;

  logic [READ_LAT-1:0] rsp_valid_q, rsp_valid_d;
  logic [READ_LAT-1:0] rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]   rsp_data_q [READ_LAT];
  logic [DATA_W-1:0]   rsp_data_d [READ_LAT];

  // Clear/ready FSM: state register
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= S_CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // Clear/ready FSM: next state
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    if (state_q == S_CLEAR) begin
      clr_idx_d = clr_idx_q + IDX_W'(1);
      if (clr_idx_q == IDX_W'(DEPTH - 1)) state_d = S_READY;
    end
  end

  // Clear/ready FSM: outputs
  always_comb begin
    ReqReady = (state_q == S_READY);
    Busy     = (state_q == S_CLEAR);
  end

  always_comb begin
    accept       = ReqValid && ReqReady;
    off          = ReqAddr[OFF_W-1:0];
    idx          = ReqAddr[OFF_W +: IDX_W];
    nbytes       = 32'd1 << ReqSize;
    nbits        = (nbytes >= BYTES) ? DATA_W : nbytes * 8;
    out_of_range = (ReqAddr >> (OFF_W + IDX_W)) != '0;
    bad_size     = nbytes > BYTES;
    misaligned   = (32'(off) & (nbytes - 32'd1)) != '0;
    req_err      = out_of_range || bad_size || misaligned;
  end

  // Single write port shared by the clear sequence and accepted stores
  always_comb begin
    mem_we    = 1'b0;
    mem_idx   = idx;
    mem_be    = BYTES'((32'd1 << nbytes) - 32'd1) << off;
    mem_wdata = ReqWData << {off, 3'b000};
    if (state_q == S_CLEAR) begin
      mem_we    = 1'b1;
      mem_idx   = clr_idx_q;
      mem_be    = '1;
      mem_wdata = '0;
    end else if (accept && ReqWrite && !req_err) begin
      mem_we    = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (mem_be[b]) mem_q[mem_idx][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
    end
  end

  // Loads read the array at accept time, so a store committed on the previous edge is visible.
  // The sign bit is the top bit of the size mask, which avoids a variable bit select.
  always_comb begin
    rd_shift    = mem_q[idx] >> {off, 3'b000};
    ext_mask    = (DATA_W'(1) << nbits) - DATA_W'(1);
    sign_bit    = |(rd_shift & ext_mask & ~(ext_mask >> 1));
    load_val    = rd_shift & ext_mask;
    if (!ReqUnsigned && sign_bit) load_val = load_val | ~ext_mask;
    rsp_data_in = (ReqWrite || req_err) ? '0 : load_val;
  end

  always_comb begin
    rsp_valid_d    = '0;
    rsp_err_d      = '0;
    rsp_data_d     = '{default: '0};
    rsp_valid_d[0] = accept;
    rsp_err_d[0]   = accept && req_err;
    rsp_data_d[0]  = accept ? rsp_data_in : '0;
    for (int unsigned i = 1; i < READ_LAT; i++) begin
      rsp_valid_d[i] = rsp_valid_q[i-1];
      rsp_err_d[i]   = rsp_err_q[i-1];
      rsp_data_d[i]  = rsp_data_q[i-1];
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      rsp_valid_q <= '0;
      rsp_err_q   <= '0;
      for (int unsigned i = 0; i < READ_LAT; i++) rsp_data_q[i] <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      for (int unsigned i = 0; i < READ_LAT; i++) rsp_data_q[i] <= rsp_data_d[i];
    end
  end

  always_comb begin
    RspValid = rsp_valid_q[READ_LAT-1];
    RspErr   = rsp_err_q[READ_LAT-1];
    RspData  = rsp_data_q[READ_LAT-1];
  end

endmodule

// File: tb/tb_data_memory_unit.sv
// Randomized bench for data_memory_unit against a byte-array reference model with
// a per-cycle compare process and literal expectations on directed transactions.
module tb_data_memory_unit;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DEPTH    = 256;
  localparam int unsigned READ_LAT = 2;

  logic              Clk = 1'b0;
  logic              Rst = 1'b0;
  logic              ReqValid = 1'b0;
  logic              ReqReady;
  logic              ReqWrite = 1'b0;
  logic [ADDR_W-1:0] ReqAddr = '0;
  logic [1:0]        ReqSize = '0;
  logic              ReqUnsigned = 1'b0;
  logic [DATA_W-1:0] ReqWData = '0;
  logic              RspValid;
  logic [DATA_W-1:0] RspData;
  logic              RspErr;
  logic              Busy;

  data_memory_unit #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .READ_LAT(READ_LAT)
  ) dut (
    .Clk(Clk), .Rst(Rst), .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
    .ReqAddr(ReqAddr), .ReqSize(ReqSize), .ReqUnsigned(ReqUnsigned), .ReqWData(ReqWData),
    .RspValid(RspValid), .RspData(RspData), .RspErr(RspErr), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int unsigned due;
    logic [31:0] data;
    logic        err;
    bit          has_lit;
    logic [31:0] lit_data;
    logic        lit_err;
  } rsp_t;

  rsp_t         exp_q[$];
  byte unsigned mem_m [DEPTH*4];
  bit           m_ready = 1'b0;
  int unsigned  clr_cnt = 0;
  int unsigned  cyc = 0;
  int           checks = 0;
  int           errors = 0;
  bit           cur_has_lit = 1'b0;
  logic [31:0]  cur_lit_data = '0;
  logic         cur_lit_err = 1'b0;

  always @(posedge Clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void model_accept();
    rsp_t        r;
    int unsigned nb, a;
    logic [63:0] v;
    a      = ReqAddr;
    nb     = 1 << ReqSize;
    r.err  = (ReqAddr >= DEPTH*4) || (nb > 4) || (ReqAddr % nb != 0);
    r.data = '0;
    if (!r.err) begin
      if (ReqWrite) begin
        for (int i = 0; i < nb; i++) mem_m[a+i] = ReqWData[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < nb; i++) v = v | (64'(mem_m[a+i]) << (8*i));
        if (!ReqUnsigned && nb < 4 && v[8*nb-1]) v = v - (64'd1 << (8*nb));
        r.data = v[31:0];
      end
    end
    r.due      = cyc + READ_LAT;
    r.has_lit  = cur_has_lit;
    r.lit_data = cur_lit_data;
    r.lit_err  = cur_lit_err;
    exp_q.push_back(r);
  endfunction

  // Reference model: acceptance, memory contents and expected responses
  initial begin
    forever begin
      @(posedge Clk or posedge Rst);
      if (Rst) begin
        exp_q.delete();
        m_ready = 1'b0;
        clr_cnt = 0;
        foreach (mem_m[i]) mem_m[i] = 8'h00;
      end else begin
        if (m_ready && ReqValid) model_accept();
        if (!m_ready) begin
          clr_cnt++;
          if (clr_cnt == DEPTH) m_ready = 1'b1;
        end
      end
    end
  end

  // Compare process
  initial begin
    bit ev;
    forever begin
      @(negedge Clk);
      chk("req_ready", ReqReady, m_ready);
      chk("busy", Busy, !m_ready);
      ev = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      chk("rsp_valid", RspValid, ev);
      if (ev) begin
        chk("rsp_data", RspData, exp_q[0].data);
        chk("rsp_err", RspErr, exp_q[0].err);
        if (exp_q[0].has_lit) begin
          chk("lit_data", RspData, exp_q[0].lit_data);
          chk("lit_err", RspErr, exp_q[0].lit_err);
        end
        void'(exp_q.pop_front());
      end else if (Rst) begin
        chk("rst_data", RspData, 0);
        chk("rst_err", RspErr, 0);
      end
    end
  end

  task automatic req(input bit wr, input logic [31:0] addr, input logic [1:0] size,
                     input bit uns, input logic [31:0] wdata,
                     input bit has_lit, input logic [31:0] lit_data, input bit lit_err);
    ReqValid     = 1'b1;
    ReqWrite     = wr;
    ReqAddr      = addr;
    ReqSize      = size;
    ReqUnsigned  = uns;
    ReqWData     = wdata;
    cur_has_lit  = has_lit;
    cur_lit_data = lit_data;
    cur_lit_err  = lit_err;
    @(posedge Clk);
    #1;
    ReqValid     = 1'b0;
    cur_has_lit  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic rand_req();
    logic [31:0] addr;
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r == 0)      addr = $urandom;
    else if (r < 5)  addr = $urandom_range(0, 63);
    else             addr = $urandom_range(0, DEPTH*4 + 15);
    req($urandom_range(0, 1), addr, 2'($urandom_range(0, 3)), $urandom_range(0, 1),
        $urandom, 1'b0, '0, 1'b0);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!m_ready && n < DEPTH + 20) begin
      idle(1);
      n++;
    end
    if (!m_ready) begin
      checks++;
      errors++;
      $display("FAIL wait_ready: got not-ready expected ready after %0d cycles", n);
    end
  endtask

  task automatic do_reset(input int n);
    Rst = 1'b1;
    idle(n);
    Rst = 1'b0;
  endtask

  initial begin
    #1;
    do_reset(3);
    idle(5);
    chk("clear_busy", Busy, 1);
    wait_ready();
    chk("clear_len", cyc, 3 + DEPTH);

    for (int w = 0; w < DEPTH; w++) req(0, 32'(w*4), 2'd2, 0, '0, 1, 32'h0, 0);

    req(1, 32'h10, 2'd2, 0, 32'hDEADBEEF, 1, 32'h0, 0);
    req(0, 32'h13, 2'd0, 0, '0, 1, 32'hFFFFFFDE, 0);
    req(0, 32'h13, 2'd0, 1, '0, 1, 32'h000000DE, 0);
    req(0, 32'h10, 2'd1, 0, '0, 1, 32'hFFFFBEEF, 0);
    req(0, 32'h10, 2'd1, 1, '0, 1, 32'h0000BEEF, 0);
    req(0, 32'h10, 2'd2, 0, '0, 1, 32'hDEADBEEF, 0);

    req(1, 32'h11, 2'd0, 0, 32'hAAAAAA55, 1, 32'h0, 0);
    req(0, 32'h10, 2'd2, 0, '0, 1, 32'hDEAD55EF, 0);
    req(0, 32'h12, 2'd1, 0, '0, 1, 32'hFFFFDEAD, 0);
    req(0, 32'h12, 2'd1, 1, '0, 1, 32'h0000DEAD, 0);
    req(0, 32'h14, 2'd2, 0, '0, 1, 32'h0, 0);
    req(0, 32'h0C, 2'd2, 0, '0, 1, 32'h0, 0);

    req(0, 32'h11, 2'd1, 0, '0, 1, 32'h0, 1);
    req(1, 32'h12, 2'd2, 0, 32'h11111111, 1, 32'h0, 1);
    req(0, 32'h400, 2'd2, 0, '0, 1, 32'h0, 1);
    req(1, 32'h10, 2'd3, 0, 32'h22222222, 1, 32'h0, 1);
    req(0, 32'h10, 2'd2, 0, '0, 1, 32'hDEAD55EF, 0);
    req(0, 32'h3FC, 2'd2, 0, '0, 1, 32'h0, 0);

    req(1, 32'h20, 2'd2, 0, 32'h12345678, 1, 32'h0, 0);
    req(0, 32'h20, 2'd2, 0, '0, 1, 32'h12345678, 0);
    idle(4);

    repeat (1500) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      else rand_req();
    end
    idle(4);

    req(1, 32'h40, 2'd2, 0, 32'hCAFEF00D, 1, 32'h0, 0);
    req(0, 32'h40, 2'd2, 0, '0, 1, 32'hCAFEF00D, 0);
    idle(4);
    req(0, 32'h40, 2'd2, 0, '0, 0, '0, 0);
    req(0, 32'h10, 2'd2, 0, '0, 0, '0, 0);
    req(0, 32'h20, 2'd2, 0, '0, 0, '0, 0);
    do_reset(2);
    repeat (30) rand_req();
    wait_ready();
    req(0, 32'h40, 2'd2, 0, '0, 1, 32'h0, 0);
    req(0, 32'h10, 2'd2, 0, '0, 1, 32'h0, 0);
    req(0, 32'h20, 2'd2, 0, '0, 1, 32'h0, 0);

    repeat (300) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      else rand_req();
    end
    idle(READ_LAT + 4);
    chk("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
